// File: rtl/rom_fetch_cache_pkg.sv
// Shared types and helpers for the ROM fetch cache.
// State encoding, bus widths and bit-reversal.
package rk8_fetch_pkg;

  localparam int ADDR_W = 24;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    PF_REQ,
    PF_WAIT
  } fetch_state_e;

  function automatic logic [WORD_W-1:0] bitrev32(
    input logic [WORD_W-1:0] w
  );
    logic [WORD_W-1:0] r;
    for (int i = 0; i < WORD_W; i++) begin
      r[i] = w[WORD_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/rom_fetch_cache_if.sv
// Core-side and SPI-side signals of the fetch cache.
// slave = the cache, master = core + SPI controller.
interface rom_fetch_cache_if;
  import rk8_fetch_pkg::*;

  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_req_valid;
  logic              cpu_req_ready;
  logic [WORD_W-1:0] cpu_rdata;
  logic              cpu_rdata_valid;
  logic              flush;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_addr_valid;
  logic              rom_addr_ready;
  logic [WORD_W-1:0] rom_data;
  logic              rom_data_valid;

  modport slave (
    input  cpu_addr,
    input  cpu_req_valid,
    output cpu_req_ready,
    output cpu_rdata,
    output cpu_rdata_valid,
    input  flush,
    output rom_addr,
    output rom_addr_valid,
    input  rom_addr_ready,
    input  rom_data,
    input  rom_data_valid
  );

  modport master (
    output cpu_addr,
    output cpu_req_valid,
    input  cpu_req_ready,
    input  cpu_rdata,
    input  cpu_rdata_valid,
    output flush,
    input  rom_addr,
    input  rom_addr_valid,
    output rom_addr_ready,
    output rom_data,
    output rom_data_valid
  );

endinterface

// File: rtl/rom_fetch_cache_line_ram.sv
// One-word-per-line cache storage: valid, tag, data.
// Two async read ports, one sync write, clear-all wins.
module fetch_line_ram
  import rk8_fetch_pkg::*;
#(
  parameter int LINES = 8,
  parameter int TAG_W = 19,
  localparam int IDX_W = $clog2(LINES)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  widx_i,
  input  logic [TAG_W-1:0]  wtag_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  ra_idx_i,
  output logic              ra_vld_o,
  output logic [TAG_W-1:0]  ra_tag_o,
  output logic [WORD_W-1:0] ra_data_o,
  input  logic [IDX_W-1:0]  rb_idx_i,
  output logic              rb_vld_o,
  output logic [TAG_W-1:0]  rb_tag_o
);

  logic [LINES-1:0]  vld_q;
  logic [TAG_W-1:0]  tag_q [LINES];
  logic [WORD_W-1:0] dat_q [LINES];

  // Valid bits: clear-all beats any concurrent fill.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
    end else if (clr_i) begin
      vld_q <= '0;
    end else if (we_i) begin
      vld_q[widx_i] <= 1'b1;
    end
  end

  // Tag/data payload; meaningless until its valid bit is set.
  always_ff @(posedge clk) begin
    if (we_i && !clr_i) begin
      tag_q[widx_i] <= wtag_i;
      dat_q[widx_i] <= wdata_i;
    end
  end

  assign ra_vld_o  = vld_q[ra_idx_i];
  assign ra_tag_o  = tag_q[ra_idx_i];
  assign ra_data_o = dat_q[ra_idx_i];
  assign rb_vld_o  = vld_q[rb_idx_i];
  assign rb_tag_o  = tag_q[rb_idx_i];

endmodule

// File: rtl/rom_fetch_cache.sv
// Instruction fetch front end with a direct-mapped cache
// in front of the SPI flash read controller.
module rom_fetch_cache
  import rk8_fetch_pkg::*;
#(
  parameter int LINES        = 8,
  parameter int PREFETCH     = 1,
  parameter int REVERSE_BITS = 1
) (
  input logic             clk,
  input logic             rstn,
  rom_fetch_cache_if.slave bus
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              live_q;

  logic [ADDR_W-1:0] pf_addr;
  logic [WORD_W-1:0] word;
  logic              ra_vld, rb_vld;
  logic [TAG_W-1:0]  ra_tag, rb_tag;
  logic [WORD_W-1:0] ra_data;
  logic              hit_cpu, hit_next;
  logic              we;
  logic [IDX_W-1:0]  widx;
  logic [TAG_W-1:0]  wtag;
  logic              req_rdy, aval;
  logic              in_pf;

  assign pf_addr = addr_q + 24'd4;
  assign word    = (REVERSE_BITS != 0) ? bitrev32(bus.rom_data)
                                       : bus.rom_data;

  // A flush in the same cycle forces a miss on both lookups.
  assign hit_cpu = ra_vld && !bus.flush &&
    (ra_tag == bus.cpu_addr[ADDR_W-1:2+IDX_W]);
  assign hit_next = rb_vld && !bus.flush &&
    (rb_tag == pf_addr[ADDR_W-1:2+IDX_W]);

  fetch_line_ram #(
    .LINES (LINES),
    .TAG_W (TAG_W)
  ) u_ram (
    .clk       (clk),
    .rstn      (rstn),
    .clr_i     (bus.flush),
    .we_i      (we),
    .widx_i    (widx),
    .wtag_i    (wtag),
    .wdata_i   (word),
    .ra_idx_i  (bus.cpu_addr[2+:IDX_W]),
    .ra_vld_o  (ra_vld),
    .ra_tag_o  (ra_tag),
    .ra_data_o (ra_data),
    .rb_idx_i  (pf_addr[2+:IDX_W]),
    .rb_vld_o  (rb_vld),
    .rb_tag_o  (rb_tag)
  );

  // State, latched address and core response registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Keeps cpu_req_ready low while reset is held.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
    end
  end

  // Next-state, fill control and handshake outputs.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    we       = 1'b0;
    widx     = addr_q[2+:IDX_W];
    wtag     = addr_q[ADDR_W-1:2+IDX_W];
    req_rdy  = 1'b0;
    aval     = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_rdy = live_q;
        if (live_q && bus.cpu_req_valid) begin
          addr_d = bus.cpu_addr & ~24'h3;
          if (hit_cpu) begin
            rdata_d  = ra_data;
            rvalid_d = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        aval = 1'b1;
        if (bus.rom_addr_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.rom_data_valid) begin
          we       = 1'b1;
          rdata_d  = word;
          rvalid_d = 1'b1;
          if (PREFETCH != 0 && !hit_next) begin
            state_d = PF_REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      PF_REQ: begin
        aval = 1'b1;
        if (bus.rom_addr_ready) begin
          state_d = PF_WAIT;
        end
      end
      PF_WAIT: begin
        widx = pf_addr[2+:IDX_W];
        wtag = pf_addr[ADDR_W-1:2+IDX_W];
        if (bus.rom_data_valid) begin
          we      = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_pf = (state_q == PF_REQ) || (state_q == PF_WAIT);

  assign bus.cpu_req_ready   = req_rdy;
  assign bus.cpu_rdata       = rdata_q;
  assign bus.cpu_rdata_valid = rvalid_q;
  assign bus.rom_addr        = in_pf ? pf_addr : addr_q;
  assign bus.rom_addr_valid  = aval;

endmodule

// File: tb/tb_rom_fetch_cache.sv
// Scoreboard bench for rom_fetch_cache with a small
// SPI controller model (stall, latency, flush injection).
module tb_rom_fetch_cache;

  localparam int LINES = 8;
  localparam int LAT   = 3;
  localparam int TMO   = 200;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  rom_fetch_cache_if bus();

  logic fl_main = 1'b0;
  logic fl_spi  = 1'b0;
  assign bus.flush = fl_main | fl_spi;

  rom_fetch_cache #(
    .LINES        (LINES),
    .PREFETCH     (1),
    .REVERSE_BITS (1)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int errs   = 0;
  int checks = 0;

  logic [31:0] exp_cpu [$];
  logic [23:0] exp_rom [$];

  int stall = 0;
  int fl_n  = 0;

  int          lat_cnt = 0;
  bit          pend    = 1'b0;
  int          scnt    = 0;
  logic [23:0] sa      = '0;
  logic [23:0] first   = '0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rev(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[31-i] = w[i];
    return r;
  endfunction

  function automatic logic [31:0] romw(input logic [23:0] a);
    if (a == 24'h000100) return 32'hDEADBEEF;
    return {a, 8'h5A} ^ 32'h1234_0000;
  endfunction

  // Core response monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rstn && bus.cpu_rdata_valid) begin
        if (exp_cpu.size() == 0)
          check("cpu_extra", 32'(exp_cpu.size()), 32'd1);
        else
          check("cpu_rdata", bus.cpu_rdata, exp_cpu.pop_front());
      end
    end
  end

  // SPI controller model
  initial begin
    bus.rom_addr_ready = 1'b0;
    bus.rom_data_valid = 1'b0;
    bus.rom_data       = '0;
    forever begin
      @(negedge clk);
      bus.rom_data_valid = 1'b0;
      bus.rom_addr_ready = 1'b0;
      fl_spi = 1'b0;
      if (!rstn) begin
        pend = 1'b0;
        scnt = 0;
      end else if (pend) begin
        check("rom_busy_valid", 32'(bus.rom_addr_valid), 32'd0);
        if (lat_cnt == 0) begin
          bus.rom_data       = rev(romw(sa));
          bus.rom_data_valid = 1'b1;
          pend = 1'b0;
          if (fl_n > 0) begin
            if (fl_n == 1) fl_spi = 1'b1;
            fl_n--;
          end
        end else begin
          lat_cnt--;
        end
      end else if (bus.rom_addr_valid) begin
        if (scnt == 0) first = bus.rom_addr;
        else check("stall_addr", 32'(bus.rom_addr), 32'(first));
        if (scnt < stall) begin
          scnt++;
        end else begin
          bus.rom_addr_ready = 1'b1;
          sa      = bus.rom_addr;
          pend    = 1'b1;
          lat_cnt = LAT;
          scnt    = 0;
          if (exp_rom.size() == 0)
            check("rom_extra", 32'(exp_rom.size()), 32'd1);
          else
            check("rom_addr", 32'(sa), 32'(exp_rom.pop_front()));
        end
      end else if (scnt > 0) begin
        check("stall_valid", 32'(bus.rom_addr_valid), 32'd1);
        scnt = 0;
      end
    end
  end

  task automatic wait_ready();
    int k;
    k = 0;
    while (!bus.cpu_req_ready && k < TMO) begin
      @(negedge clk);
      k++;
    end
    if (k >= TMO) check("ready_timeout", 32'(bus.cpu_req_ready), 32'd1);
  endtask

  task automatic fetch(input logic [23:0] a, input bit hit,
                       input bit pf, input bit fl);
    logic [23:0] al;
    int n;
    al = a & ~24'h3;
    wait_ready();
    exp_cpu.push_back(romw(al));
    if (!hit) exp_rom.push_back(al);
    if (pf) exp_rom.push_back(al + 24'd4);
    bus.cpu_addr      = a;
    bus.cpu_req_valid = 1'b1;
    fl_main           = fl;
    @(negedge clk);
    bus.cpu_req_valid = 1'b0;
    fl_main           = 1'b0;
    n = 1;
    while (!bus.cpu_rdata_valid && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("lat_%h", al), 32'(n),
          hit ? 32'd1 : 32'(3 + LAT + stall));
    wait_ready();
  endtask

  task automatic chk_zero(input string pfx);
    check({pfx, "_ready"},  32'(bus.cpu_req_ready), 32'd0);
    check({pfx, "_rvalid"}, 32'(bus.cpu_rdata_valid), 32'd0);
    check({pfx, "_rdata"},  bus.cpu_rdata, 32'd0);
    check({pfx, "_aval"},   32'(bus.rom_addr_valid), 32'd0);
    check({pfx, "_addr"},   32'(bus.rom_addr), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cpu_addr      = '0;
    bus.cpu_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rstn = 1'b1;
    @(negedge clk);

    // cold miss, then prefetch of next word
    fetch(24'h000100, 0, 1, 0);
    // hits, including an unaligned address
    fetch(24'h000104, 1, 0, 0);
    fetch(24'h000107, 1, 0, 0);
    // conflict on line 0
    fetch(24'h000100, 1, 0, 0);
    fetch(24'h000100 + 24'(4 * LINES), 0, 1, 0);
    fetch(24'h000100, 0, 1, 0);
    // prefetch address wraps
    fetch(24'hFFFFFC, 0, 1, 0);
    fetch(24'h000000, 1, 0, 0);
    // flush on demand fill: answered, not written
    fl_n = 1;
    fetch(24'h000200, 0, 1, 0);
    fetch(24'h000200, 0, 0, 0);
    // flush on prefetch fill: discarded
    fl_n = 2;
    fetch(24'h000300, 0, 1, 0);
    fetch(24'h000304, 0, 1, 0);
    // flush with IDLE accept forces a miss
    fetch(24'h000304, 0, 1, 1);

    // reset in WAIT
    wait_ready();
    exp_rom.push_back(24'h000400);
    bus.cpu_addr      = 24'h000400;
    bus.cpu_req_valid = 1'b1;
    @(negedge clk);
    bus.cpu_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk_zero("rst_wait");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    stall = 5;
    fetch(24'h000304, 0, 1, 0);
    stall = 0;
    fetch(24'h000308, 1, 0, 0);

    repeat (4) @(negedge clk);
    check("cpu_q_left", 32'(exp_cpu.size()), 32'd0);
    check("rom_q_left", 32'(exp_rom.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
